// File: rtl/spi_txn_scheduler.sv
// Request FIFO feeding a fixed-duration SPI controller transaction, with the
// received byte returned through a valid/ready response port.
module spi_txn_scheduler #(
    parameter int unsigned DATA_W           = 8,
    parameter int unsigned RESP_W           = 8,
    parameter int unsigned PERIPHERY_SELECT = 2,
    parameter int unsigned FIFO_DEPTH       = 4,
    parameter int unsigned TXN_CYCLES       = 23,
    parameter int unsigned GAP_CYCLES       = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [PERIPHERY_SELECT-1:0]   req_cs,
    input  logic [DATA_W-1:0]             req_data,
    output logic                          start_comm,
    output logic [PERIPHERY_SELECT-1:0]   CS_in,
    output logic [DATA_W-1:0]             data_send_c,
    input  logic [RESP_W-1:0]             cipo_register,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [PERIPHERY_SELECT-1:0]   rsp_cs,
    output logic [RESP_W-1:0]             rsp_data,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNTF_W  = PTR_W + 1;
    localparam int unsigned ENTRY_W = PERIPHERY_SELECT + DATA_W;
    localparam int unsigned CNT_W   = (TXN_CYCLES > 1) ? $clog2(TXN_CYCLES) : 1;
    localparam int unsigned GCNT_W  = $clog2(GAP_CYCLES) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t state, state_d;

    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic               push, launch, capture, gap_done;
    logic [ENTRY_W-1:0] head;

    logic [CNT_W-1:0]            cnt, cnt_d;
    logic [GCNT_W-1:0]           gcnt, gcnt_d;
    logic                        start_comm_d, rsp_valid_d;
    logic [PERIPHERY_SELECT-1:0] cs_d, rsp_cs_d;
    logic [DATA_W-1:0]           data_d;
    logic [RESP_W-1:0]           rsp_data_d;

    assign req_ready = (fifo_count != CNTF_W'(FIFO_DEPTH));
    assign push      = req_valid && req_ready;
    assign launch    = (state == S_IDLE) && (fifo_count != '0) && !rsp_valid;
    assign capture   = (state == S_WAIT) && (cnt == CNT_W'(TXN_CYCLES - 1));
    assign gap_done  = (state == S_GAP) && (gcnt == GCNT_W'(GAP_CYCLES - 1));
    assign head      = mem[rd_ptr];
    assign busy      = (state != S_IDLE);

    // Storage is not reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {req_cs, req_data};
        end
    end

    // FIFO pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (launch) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, launch})
                2'b10:   fifo_count <= fifo_count + CNTF_W'(1);
                2'b01:   fifo_count <= fifo_count - CNTF_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (launch)   state_d = S_WAIT;
            S_WAIT:  if (capture)  state_d = S_GAP;
            S_GAP:   if (gap_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and timing counters.
    always_comb begin
        start_comm_d = 1'b0;
        cs_d         = CS_in;
        data_d       = data_send_c;
        cnt_d        = cnt;
        gcnt_d       = gcnt;
        rsp_valid_d  = rsp_valid && !rsp_ready;
        rsp_cs_d     = rsp_cs;
        rsp_data_d   = rsp_data;
        case (state)
            S_IDLE: begin
                if (launch) begin
                    start_comm_d = 1'b1;
                    cs_d         = head[ENTRY_W-1:DATA_W];
                    data_d       = head[DATA_W-1:0];
                    cnt_d        = '0;
                end
            end
            S_WAIT: begin
                if (capture) begin
                    rsp_valid_d = 1'b1;
                    rsp_cs_d    = CS_in;
                    rsp_data_d  = cipo_register;
                    gcnt_d      = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_GAP: begin
                gcnt_d = gcnt + GCNT_W'(1);
            end
            default: begin
                cnt_d = cnt;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_comm  <= 1'b0;
            CS_in       <= '0;
            data_send_c <= '0;
            cnt         <= '0;
            gcnt        <= '0;
            rsp_valid   <= 1'b0;
            rsp_cs      <= '0;
            rsp_data    <= '0;
        end else begin
            start_comm  <= start_comm_d;
            CS_in       <= cs_d;
            data_send_c <= data_d;
            cnt         <= cnt_d;
            gcnt        <= gcnt_d;
            rsp_valid   <= rsp_valid_d;
            rsp_cs      <= rsp_cs_d;
            rsp_data    <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_spi_txn_scheduler.sv
// Scoreboard bench for spi_txn_scheduler: expected launches/responses are queued
// at push time and checked by a negedge monitor.
module tb_spi_txn_scheduler;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_cs;
    logic [7:0] req_data;
    logic       start_comm;
    logic [1:0] CS_in;
    logic [7:0] data_send_c;
    logic [7:0] cipo_register;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [1:0] rsp_cs;
    logic [7:0] rsp_data;
    logic       busy;
    logic [2:0] fifo_count;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [9:0] launch_q[$];
    logic [9:0] rsp_q[$];
    logic [7:0] cipo_q[$];
    int         launch_times[$];

    spi_txn_scheduler dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_cs(req_cs), .req_data(req_data),
        .start_comm(start_comm), .CS_in(CS_in), .data_send_c(data_send_c),
        .cipo_register(cipo_register),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_cs(rsp_cs), .rsp_data(rsp_data),
        .busy(busy), .fifo_count(fifo_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle request; expectations are queued only if the DUT accepts it.
    task automatic push(input logic [1:0] cs, input logic [7:0] d, input logic [7:0] c, output bit acc);
        req_valid = 1'b1;
        req_cs    = cs;
        req_data  = d;
        @(negedge clk);
        acc = req_ready;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (acc) begin
            launch_q.push_back({cs, d});
            rsp_q.push_back({cs, c});
            cipo_q.push_back(c);
        end
    endtask

    task automatic wait_idle(input int maxc, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < maxc && !ok; i++) begin
            tick();
            if (fifo_count == 3'd0 && !busy && !rsp_valid) ok = 1'b1;
        end
        check(name, 32'(ok), 32'd1);
    endtask

    task automatic wait_rsp(input int maxc, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < maxc && !ok; i++) begin
            tick();
            if (rsp_valid) ok = 1'b1;
        end
        check(name, 32'(ok), 32'd1);
    endtask

    // Monitor: checks launches and responses against the scoreboard queues.
    always @(negedge clk) begin
        logic [9:0] e;
        if (rst) begin
            if (start_comm) begin
                launch_times.push_back(cyc);
                if (launch_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_launch: got cs=%0h data=%0h expected none", CS_in, data_send_c);
                end else begin
                    e = launch_q.pop_front();
                    check("launch_cs", 32'(CS_in), 32'(e[9:8]));
                    check("launch_data", 32'(data_send_c), 32'(e[7:0]));
                end
                if (cipo_q.size() != 0) cipo_register = cipo_q.pop_front();
            end
            if (rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_rsp: got cs=%0h data=%0h expected none", rsp_cs, rsp_data);
                end else if (rsp_ready) begin
                    e = rsp_q.pop_front();
                    check("rsp_cs", 32'(rsp_cs), 32'(e[9:8]));
                    check("rsp_data", 32'(rsp_data), 32'(e[7:0]));
                end else begin
                    e = rsp_q[0];
                    check("rsp_hold_cs", 32'(rsp_cs), 32'(e[9:8]));
                    check("rsp_hold_data", 32'(rsp_data), 32'(e[7:0]));
                end
            end
        end
    end

    initial begin
        bit acc;
        int quiet;
        rst = 1'b0;
        req_valid = 1'b0;
        req_cs = 2'd0;
        req_data = 8'd0;
        rsp_ready = 1'b0;
        cipo_register = 8'd0;
        repeat (3) tick();
        check("reset_start_comm", 32'(start_comm), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_fifo_count", 32'(fifo_count), 32'd0);
        rst = 1'b1;
        tick();

        // Single transaction: launch latency and response timing.
        rsp_ready = 1'b1;
        push(2'd2, 8'hA5, 8'h3C, acc);
        check("t2_accept", 32'(acc), 32'd1);
        check("t2_no_launch_e0", 32'(start_comm), 32'd0);
        tick();
        check("t2_launch_e1", 32'(start_comm), 32'd1);
        check("t2_cs_in", 32'(CS_in), 32'd2);
        check("t2_data_send", 32'(data_send_c), 32'hA5);
        tick();
        check("t2_pulse_end", 32'(start_comm), 32'd0);
        check("t2_busy", 32'(busy), 32'd1);
        repeat (21) tick();
        check("t2_rsp_early", 32'(rsp_valid), 32'd0);
        tick();
        check("t2_rsp_e24", 32'(rsp_valid), 32'd1);
        check("t2_rsp_cs", 32'(rsp_cs), 32'd2);
        check("t2_rsp_data", 32'(rsp_data), 32'h3C);
        wait_idle(20, "t2_idle");

        // Backpressure: full FIFO rejects, held response blocks launches.
        rsp_ready = 1'b0;
        push(2'd1, 8'h5A, 8'hC1, acc);
        wait_rsp(40, "t3_rsp_arrive");
        for (int i = 0; i < 5; i++) begin
            push(2'(i % 4), 8'(8'h20 + i), 8'(8'hD0 + i), acc);
            check("t3_push_accept", 32'(acc), (i < 4) ? 32'd1 : 32'd0);
        end
        check("t3_fifo_count", 32'(fifo_count), 32'd4);
        check("t3_req_ready", 32'(req_ready), 32'd0);
        quiet = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (start_comm || !rsp_valid) quiet++;
        end
        check("t4_blocked", 32'(quiet), 32'd0);
        rsp_ready = 1'b1;
        tick();
        check("t4_rsp_cleared", 32'(rsp_valid), 32'd0);
        check("t4_no_launch_at_hs", 32'(start_comm), 32'd0);
        tick();
        check("t4_launch_after_hs", 32'(start_comm), 32'd1);
        wait_idle(4 * 26 + 20, "t3_drain");

        // Back-to-back launches spaced by transaction + gap + 1.
        launch_times.delete();
        for (int i = 0; i < 4; i++) begin
            push(2'(i), 8'(8'h10 + i), 8'(8'h80 + i), acc);
        end
        wait_idle(200, "t5_drain");
        check("t5_launch_count", 32'(launch_times.size()), 32'd4);
        if (launch_times.size() == 4) begin
            for (int i = 1; i < 4; i++) begin
                check("t5_spacing", 32'(launch_times[i] - launch_times[i-1]), 32'd26);
            end
        end

        // Push on the same edge as a launch pop with the FIFO half full.
        rsp_ready = 1'b0;
        push(2'd3, 8'h40, 8'hE0, acc);
        wait_rsp(40, "t6_rsp_arrive");
        push(2'd1, 8'h41, 8'hE1, acc);
        push(2'd2, 8'h42, 8'hE2, acc);
        check("t6_half_full", 32'(fifo_count), 32'd2);
        rsp_ready = 1'b1;
        tick();
        push(2'd0, 8'h43, 8'hE3, acc);
        check("t6_same_edge_launch", 32'(start_comm), 32'd1);
        check("t6_count_unchanged", 32'(fifo_count), 32'd2);
        wait_idle(150, "t6_drain");

        // Asynchronous reset in the middle of a transaction.
        for (int i = 0; i < 4; i++) begin
            push(2'(i), 8'(8'h50 + i), 8'(8'h90 + i), acc);
        end
        check("t1_queued", 32'(fifo_count), 32'd3);
        repeat (5) tick();
        check("t1_mid_wait", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("t1_rst_start_comm", 32'(start_comm), 32'd0);
        check("t1_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t1_rst_fifo_count", 32'(fifo_count), 32'd0);
        check("t1_rst_busy", 32'(busy), 32'd0);
        launch_q.delete();
        rsp_q.delete();
        cipo_q.delete();
        repeat (2) tick();
        rst = 1'b1;
        quiet = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (rsp_valid || start_comm || busy) quiet++;
        end
        check("t1_quiet_after_reset", 32'(quiet), 32'd0);
        check("t1_fifo_empty", 32'(fifo_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
